link_rx: RTL
============

# link_rx

Receive end of the inter-board UART link: recovers bytes from the serial `rx` line and decodes them into game messages (opponent direction, food seed, start-game) for the snake core. Sits between the board's `rx` pin and the consumers in the top level (`move`, `generate_point`, `mode_control`). It is the decoding counterpart to the transmitter inside `communicate`, which it can replace for the receive half.

## Interface
- `CLK_HZ`, default 75_000_000: frequency of `clk` in Hz.
- `BAUD`, default 115_200: line rate; `CLKS_PER_BIT = CLK_HZ/BAUD`, integer division, at least 8.
- `clk`  in  1  system clock (75 MHz domain).
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `dir2`  out  `direction`  last received opponent direction.
- `rcvdir`  out  1  one-cycle pulse when `dir2` is updated.
- `seed_x_out`, `seed_y_out`  out  5 each  last complete seed pair.
- `seed_rdy`  out  1  one-cycle pulse when a seed pair is updated.
- `start_game`  out  1  one-cycle pulse on a start message.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit (or bad parity, see Configuration).

## Operation
- Byte layout: bits [7:6] are the type and bits [5:0] the payload. Type 00 = START (payload ignored); 01 = DIR (payload[1:0] cast to `direction`); 10 = SEED_X (payload[4:0]); 11 = SEED_Y (payload[4:0]).
- `rx` passes through a 2-flop synchronizer; both flops reset to 1.
- Byte FSM states:
  - IDLE: a synchronized falling edge moves to START.
  - START: at `CLKS_PER_BIT/2` samples the line; if 1 (glitch), return to IDLE, otherwise go to DATA.
  - DATA: takes 8 samples LSB first, one every `CLKS_PER_BIT`.
  - STOP: samples the line. If 1, raise `byte_valid`. If 0, pulse `frame_err`, discard the byte, and hold in STOP until the line reads 1, then go to IDLE.
- Parser FSM states:
  - P_ANY: DIR updates `dir2` and pulses `rcvdir`. START pulses `start_game`. SEED_X latches a pending x and goes to P_SEED_Y. SEED_Y is ignored.
  - P_SEED_Y: SEED_Y writes `seed_x_out`/`seed_y_out` together, pulses `seed_rdy`, and returns to P_ANY. A second SEED_X replaces the pending x and stays. Any other type drops the pending x, is processed exactly as in P_ANY, and returns to P_ANY. A `frame_err` drops the pending x and returns to P_ANY.
- Only one pulse output can be high in a given cycle, since messages arrive one byte at a time.
- Reset values: `dir2 = direction'(0)`, `seed_x_out = 0`, `seed_y_out = 0`, all pulse outputs 0, both FSMs idle, pending x cleared.
- Reset asserted mid-byte or mid-pair: the partial data is discarded. After release, nothing is decoded until a fresh falling edge.

## Timing
- Bit counter range is 0..`CLKS_PER_BIT-1`. It restarts at the falling edge, so each sample lands mid-bit ±1 cycle plus the synchronizer delay.
- `byte_valid` is high in the cycle after the stop-bit sample.
- Decoded outputs and pulses register on the next edge, 2 cycles after the stop sample.
- Every pulse is exactly 1 cycle wide.
- Back-to-back bytes (next start bit immediately after the stop bit) must decode without loss. STOP returns to IDLE right after the sample, with at least `CLKS_PER_BIT/2` cycles of margin.

## Configuration
- `LINK_PARITY_EN` defined: frames are 8E1. A PARITY state between DATA and STOP checks even parity. On a mismatch it pulses `frame_err` and discards the byte; the stop bit is still consumed.
- `LINK_PARITY_EN` undefined: frames are 8N1 and there is no PARITY state.

## Structure
- `snake_pkg` holds:
  - the `link_msg` enum {MSG_START, MSG_DIR, MSG_SEED_X, MSG_SEED_Y};
  - constants `LINK_TYPE_MSB = 7`, `LINK_TYPE_LSB = 6`;
  - the existing `direction` type.
- One sub-module, `link_uart_rx`: synchronizer plus byte FSM, outputs `byte_data[7:0]`, `byte_valid`, `frame_err`. The parser FSM lives in `link_rx`.

## Test plan
Bench uses `CLK_HZ=1_000_000` and `BAUD=100_000`, giving 10 clocks per bit.
- DIR byte 0x42 sent 8N1 -> `dir2 = direction'(2)` and one `rcvdir` pulse, 2 cycles after the stop sample. No other pulses.
- 0x93 then 0xD5, back to back -> `seed_x_out = 19`, `seed_y_out = 21`, one `seed_rdy` pulse. Outputs stay unchanged before the second byte.
- 0x93, 0x41, 0xD5 -> `rcvdir` with `dir2 = 1`. No `seed_rdy`; the seed outputs keep their old values.
- 0x05 whose stop bit is held 0 for 15 cycles -> one `frame_err` pulse, no `start_game`. A following 0x00 -> one `start_game` pulse.
- A 3-cycle low glitch on idle `rx` -> no outputs change. Reset asserted in the middle of 0x7F -> all outputs return to reset values, and a following 0x43 decodes correctly.
- With `LINK_PARITY_EN`: 0x42 sent with a wrong parity bit -> `frame_err` and `dir2` unchanged. Sent with correct parity -> `rcvdir` pulse.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake link: direction, link message types and the
// receive-side FSM state encodings exposed for debug.
package snake_pkg;

   typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} direction;

   typedef enum logic [1:0] {MSG_START, MSG_DIR, MSG_SEED_X, MSG_SEED_Y} link_msg;

   localparam int LINK_TYPE_MSB = 7;
   localparam int LINK_TYPE_LSB = 6;

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
   typedef enum logic {P_ANY, P_SEED_Y} parse_state_t;

   // Message type carried in the top two bits of a link byte.
   function automatic link_msg msg_type(input logic [7:0] b);
      return link_msg'(b[LINK_TYPE_MSB:LINK_TYPE_LSB]);
   endfunction

endpackage

// File: rtl/link_rx_if.sv
// Decoded-message bundle from link_rx to the game consumers.
// Pulses (rcvdir, seed_rdy, start_game, frame_err) are single-cycle strobes
// with no back-pressure: the consumer must accept them in the cycle they are
// high; dir2/seed_x_out/seed_y_out hold their value between pulses.
// rx_state, parse_state and last_byte are debug visibility only.
interface link_rx_if;
   import snake_pkg::*;

   direction     dir2;
   logic         rcvdir;
   logic [4:0]   seed_x_out;
   logic [4:0]   seed_y_out;
   logic         seed_rdy;
   logic         start_game;
   logic         frame_err;
   rx_state_t    rx_state;
   parse_state_t parse_state;
   logic [7:0]   last_byte;

   modport master (output dir2, rcvdir, seed_x_out, seed_y_out, seed_rdy,
                          start_game, frame_err, rx_state, parse_state, last_byte);
   modport slave  (input  dir2, rcvdir, seed_x_out, seed_y_out, seed_rdy,
                          start_game, frame_err, rx_state, parse_state, last_byte);
endinterface

// File: rtl/link_uart_rx.sv
// UART byte receiver: 2-flop synchronizer plus byte FSM.
// Optional feature: define LINK_PARITY_EN for 8E1 frames (even parity);
// default build receives 8N1.
module link_uart_rx
   import snake_pkg::*;
#(
   parameter int CLKS_PER_BIT = 651
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err,
   output rx_state_t  state
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

   logic s1, s2, s3;
   logic [CW-1:0] cnt, cnt_n;
   logic [7:0] shift, shift_n;
   logic [2:0] idx, idx_n;
   logic hold, hold_n;
   logic par_bad, par_bad_n;
   logic valid_n, err_n;
   rx_state_t state_n;
   logic fall, tick;

   assign fall      = s3 & ~s2;
   assign tick      = (cnt == LAST);
   assign byte_data = shift;

   // Synchronizer (idle high) plus one extra stage for falling-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= rx;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // FSM state and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RX_IDLE;
         cnt        <= '0;
         shift      <= '0;
         idx        <= '0;
         hold       <= 1'b0;
         par_bad    <= 1'b0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         shift      <= shift_n;
         idx        <= idx_n;
         hold       <= hold_n;
         par_bad    <= par_bad_n;
         byte_valid <= valid_n;
         frame_err  <= err_n;
      end
   end

   // Next-state: bit timing restarts at the falling edge so each sample sits mid-bit.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt + CW'(1);
      shift_n   = shift;
      idx_n     = idx;
      hold_n    = hold;
      par_bad_n = par_bad;
      valid_n   = 1'b0;
      err_n     = 1'b0;
      case (state)
         RX_IDLE: begin
            cnt_n  = '0;
            hold_n = 1'b0;
            if (fall) state_n = RX_START;
         end
         RX_START: begin
            if (cnt == HALF_M1) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = s2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (tick) begin
               cnt_n   = '0;
               shift_n = {s2, shift[7:1]};
               idx_n   = idx + 3'd1;
               if (idx == 3'd7) begin
`ifdef LINK_PARITY_EN
                  state_n = RX_PARITY;
`else
                  state_n = RX_STOP;
`endif
               end
            end
         end
`ifdef LINK_PARITY_EN
         RX_PARITY: begin
            if (tick) begin
               cnt_n     = '0;
               par_bad_n = ^{shift, s2};
               state_n   = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            if (hold) begin
               // Broken stop bit: wait for the line to return high.
               cnt_n = '0;
               if (s2) state_n = RX_IDLE;
            end else if (tick) begin
               cnt_n = '0;
               if (!s2) begin
                  err_n  = 1'b1;
                  hold_n = 1'b1;
               end else begin
                  if (par_bad) err_n = 1'b1;
                  else         valid_n = 1'b1;
                  state_n = RX_IDLE;
               end
            end
         end
         default: state_n = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/link_rx.sv
// Link receiver top: UART byte receiver plus message parser that turns bytes
// into direction, seed-pair and start-game events.
// Optional feature: LINK_PARITY_EN (8E1 frames, handled in link_uart_rx).
module link_rx
   import snake_pkg::*;
#(
   parameter int CLK_HZ = 75_000_000,
   parameter int BAUD   = 115_200
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      rx,
   link_rx_if.master link
);

   // Must be at least 8 for the mid-bit sampling to have margin.
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

   logic [7:0] byte_data;
   logic byte_valid, byte_err;
   rx_state_t rx_state;

   link_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .frame_err  (byte_err),
      .state      (rx_state)
   );

   parse_state_t pstate, pstate_n;
   logic [4:0] pend, pend_n;
   direction dir_q, dir_n;
   logic [4:0] sx_q, sx_n, sy_q, sy_n;
   logic rcv_q, rcv_n, seed_q, seed_n, start_q, start_n, ferr_q, ferr_n;
   logic as_any;
   link_msg msg;

   assign msg = msg_type(byte_data);

   // Parser state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pstate  <= P_ANY;
         pend    <= '0;
         dir_q   <= direction'(2'd0);
         sx_q    <= '0;
         sy_q    <= '0;
         rcv_q   <= 1'b0;
         seed_q  <= 1'b0;
         start_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         pstate  <= pstate_n;
         pend    <= pend_n;
         dir_q   <= dir_n;
         sx_q    <= sx_n;
         sy_q    <= sy_n;
         rcv_q   <= rcv_n;
         seed_q  <= seed_n;
         start_q <= start_n;
         ferr_q  <= ferr_n;
      end
   end

   // Decode: a seed pair is only published when SEED_Y directly follows SEED_X.
   always_comb begin
      pstate_n = pstate;
      pend_n   = pend;
      dir_n    = dir_q;
      sx_n     = sx_q;
      sy_n     = sy_q;
      rcv_n    = 1'b0;
      seed_n   = 1'b0;
      start_n  = 1'b0;
      ferr_n   = 1'b0;
      as_any   = 1'b0;
      if (byte_err) begin
         ferr_n   = 1'b1;
         pend_n   = '0;
         pstate_n = P_ANY;
      end else if (byte_valid) begin
         if (pstate == P_SEED_Y) begin
            if (msg == MSG_SEED_Y) begin
               sx_n     = pend;
               sy_n     = byte_data[4:0];
               seed_n   = 1'b1;
               pend_n   = '0;
               pstate_n = P_ANY;
            end else if (msg == MSG_SEED_X) begin
               pend_n = byte_data[4:0];
            end else begin
               pend_n   = '0;
               pstate_n = P_ANY;
               as_any   = 1'b1;
            end
         end else begin
            as_any = 1'b1;
         end
      end
      if (as_any) begin
         case (msg)
            MSG_DIR: begin
               dir_n = direction'(byte_data[1:0]);
               rcv_n = 1'b1;
            end
            MSG_START: start_n = 1'b1;
            MSG_SEED_X: begin
               pend_n   = byte_data[4:0];
               pstate_n = P_SEED_Y;
            end
            default: ;
         endcase
      end
   end

   assign link.dir2        = dir_q;
   assign link.rcvdir      = rcv_q;
   assign link.seed_x_out  = sx_q;
   assign link.seed_y_out  = sy_q;
   assign link.seed_rdy    = seed_q;
   assign link.start_game  = start_q;
   assign link.frame_err   = ferr_q;
   assign link.rx_state    = rx_state;
   assign link.parse_state = pstate;
   assign link.last_byte   = byte_data;

endmodule
